// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with an in-order response buffer and redirect discard.
// Define FETCH_PREFETCH_EN for a 2-entry buffer with 2 outstanding requests (default: 1 and 1).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        incr_pc_i,
    input  logic        pc_load_i,
    input  logic [31:0] pc_load_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] d_inst_o,
    output logic        d_valid_o,
    output logic [31:0] d_pc_o,
    output logic [31:0] x_pc_o
);
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic [31:0] fetch_pc, last_pc;
    logic [31:0] buf_inst [DEPTH];
    logic [31:0] buf_pc [DEPTH];
    logic [1:0]  fifo_cnt, out_cnt;
    logic [3:0]  disc_cnt;
    logic        rd_ptr, wr_ptr, grant, push, pop, drop, empty;
    assign empty       = fifo_cnt == 2'd0;
    assign imem_req_o  = rst_n_i && !pc_load_i && (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'(DEPTH));
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign drop        = disc_cnt != 4'd0;
    assign push        = imem_rvalid_i && !drop && !pc_load_i;
    assign pop         = incr_pc_i && !empty && !pc_load_i;
    assign d_valid_o   = !empty;
    assign d_inst_o    = empty ? NOP_INST : buf_inst[rd_ptr];
    assign d_pc_o      = empty ? last_pc : buf_pc[rd_ptr];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc <= RESET_PC;
            x_pc_o   <= '0;
            last_pc  <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
            disc_cnt <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            if (!empty) last_pc <= buf_pc[rd_ptr];
            if (pc_load_i) begin
                // every live request becomes a discard; a response landing now is already dropped
                fetch_pc <= pc_load_addr_i & ~32'd3;
                fifo_cnt <= '0;
                out_cnt  <= '0;
                disc_cnt <= disc_cnt + {2'b00, out_cnt} - {3'b000, imem_rvalid_i};
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (imem_rvalid_i && drop) disc_cnt <= disc_cnt - 4'd1;
                out_cnt  <= out_cnt + {1'b0, grant} - {1'b0, push};
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
                if (push) wr_ptr <= wr_ptr + 1'(DEPTH - 1);
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'(DEPTH - 1);
                    x_pc_o <= buf_pc[rd_ptr];
                end
            end
        end
    end
    // live requests are consecutive words ending just below fetch_pc, so the oldest one's address is implied
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata_i;
            buf_pc[wr_ptr]   <= fetch_pc - {28'd0, out_cnt, 2'b00};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit, checked against a queue/epoch model of fetch and decode.
`timescale 1ns/1ps
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk_i = 0, rst_n_i = 0, incr_pc_i = 0, pc_load_i = 0, imem_gnt_i = 0, imem_rvalid_i = 0;
    logic [31:0] pc_load_addr_i = 0, imem_rdata_i = 0;
    logic imem_req_o, d_valid_o;
    logic [31:0] imem_addr_o, d_inst_o, d_pc_o, x_pc_o;
    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .incr_pc_i(incr_pc_i), .pc_load_i(pc_load_i),
        .pc_load_addr_i(pc_load_addr_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .d_inst_o(d_inst_o), .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .x_pc_o(x_pc_o)
    );
    always #5 clk_i = ~clk_i;
    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    req_t mem_q[$];
    ent_t exp_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] exp_fetch = RESET_PC, exp_x_pc = 0;
    int epoch = 0, cyc = 0, lat_lo = 1, lat_hi = 1, gnt_pct = 100;
    int total = 0, bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        exp_fetch = RESET_PC;
        exp_x_pc = 0;
        epoch++;
    endtask

    // one clock: sample inputs/handshakes, advance the model, then drive the memory side for the next cycle
    task automatic tick();
        logic s_req, s_gnt, s_rv, s_load, s_incr;
        logic [31:0] s_addr, s_ld;
        req_t r;
        ent_t e;
        #1;
        s_req = imem_req_o; s_gnt = imem_gnt_i; s_rv = imem_rvalid_i; s_load = pc_load_i;
        s_incr = incr_pc_i; s_addr = imem_addr_o; s_ld = pc_load_addr_i;
        @(posedge clk_i);
        if (!rst_n_i) model_reset();
        else begin
            if (s_load) begin
                exp_q.delete();
                epoch++;
                exp_fetch = s_ld & ~32'd3;
            end else if (s_incr && exp_q.size() > 0) begin
                exp_x_pc = exp_q[0].pc;
                exp_q.delete(0);
            end
            if (s_rv && mem_q.size() > 0) begin
                r = mem_q.pop_front();
                if (!s_load && r.epoch == epoch) begin
                    e.inst = mem_word(r.addr);
                    e.pc = r.addr;
                    exp_q.push_back(e);
                end
            end
            if (s_req && s_gnt) begin
                r.addr = s_addr;
                r.epoch = epoch;
                r.due = cyc + int'($urandom_range(lat_hi, lat_lo));
                mem_q.push_back(r);
                grant_log.push_back(s_addr);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
        #1;
        imem_rvalid_i = rst_n_i && mem_q.size() > 0 && mem_q[0].due <= cyc;
        imem_rdata_i = imem_rvalid_i ? mem_word(mem_q[0].addr) : $urandom;
        imem_gnt_i = $urandom_range(99, 0) < gnt_pct;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #2;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req_o); end
        total++; if (d_valid_o !== 1'b0) begin bad++; $display("FAIL reset_dvalid got=%b want=0", d_valid_o); end
        total++; if (d_inst_o !== NOP) begin bad++; $display("FAIL reset_dinst got=%h want=%h", d_inst_o, NOP); end
        total++; if (d_pc_o !== 32'h0) begin bad++; $display("FAIL reset_dpc got=%h want=0", d_pc_o); end
        total++; if (x_pc_o !== 32'h0) begin bad++; $display("FAIL reset_xpc got=%h want=0", x_pc_o); end
        total++; if (imem_addr_o !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr_o, RESET_PC); end
        model_reset();
    endtask

    task automatic test_sequential();
        int first = 0, n = 0;
        gnt_pct = 100; lat_lo = 1; lat_hi = 1; incr_pc_i = 1; imem_gnt_i = 1;
        grant_log.delete();
        rst_n_i = 1;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (first == 0 && d_valid_o === 1'b1) first = c;
            if (d_valid_o === 1'b1) begin
                total++; if (d_pc_o !== 32'(4 * n)) begin bad++; $display("FAIL seq_dpc got=%h want=%h", d_pc_o, 32'(4 * n)); end
                total++; if (d_inst_o !== mem_word(32'(4 * n))) begin bad++; $display("FAIL seq_dinst got=%h want=%h", d_inst_o, mem_word(32'(4 * n))); end
                n++;
            end
            tick();
        end
        total++; if (first != 3) begin bad++; $display("FAIL seq_first_valid got=%0d want=3", first); end
        total++; if (grant_log.size() < 3) begin bad++; $display("FAIL seq_grants got=%0d want>=3", grant_log.size()); end
        else for (int i = 0; i < 3; i++) begin
            total++; if (grant_log[i] !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h want=%h", i, grant_log[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        int g0;
        logic [31:0] held, x_hold;
        logic have = 0;
        incr_pc_i = 0;
        g0 = grant_log.size();
        x_hold = exp_x_pc;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (!have && exp_q.size() > 0) begin held = exp_q[0].inst; have = 1; end
            if (have) begin
                total++; if (d_inst_o !== held) begin bad++; $display("FAIL stall_hold got=%h want=%h", d_inst_o, held); end
            end
            total++; if (x_pc_o !== x_hold) begin bad++; $display("FAIL stall_xpc got=%h want=%h", x_pc_o, x_hold); end
            tick();
        end
        total++; if (grant_log.size() - g0 > DEPTH) begin bad++; $display("FAIL stall_reqs got=%0d want<=%0d", grant_log.size() - g0, DEPTH); end
    endtask

    task automatic test_redirect();
        int k;
        lat_lo = 3; lat_hi = 3; gnt_pct = 100; incr_pc_i = 1;
        for (k = 0; k < 20 && live_cnt() < DEPTH; k++) tick();
        total++; if (live_cnt() < DEPTH) begin bad++; $display("FAIL redir_inflight got=%0d want=%0d", live_cnt(), DEPTH); end
        pc_load_i = 1; pc_load_addr_i = 32'h100;
        #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL redir_req_on_load got=%b want=0", imem_req_o); end
        tick();
        pc_load_i = 0;
        #1;
        total++; if (x_pc_o !== exp_x_pc) begin bad++; $display("FAIL redir_xpc got=%h want=%h", x_pc_o, exp_x_pc); end
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_next_req got=%b/%h want=1/00000100", imem_req_o, imem_addr_o); end
        for (k = 0; k < 30 && d_valid_o !== 1'b1; k++) tick();
        total++; if (d_valid_o !== 1'b1 || d_pc_o !== 32'h100) begin bad++; $display("FAIL redir_first_pc got=%b/%h want=1/00000100", d_valid_o, d_pc_o); end
        total++; if (d_inst_o !== mem_word(32'h100)) begin bad++; $display("FAIL redir_first_inst got=%h want=%h", d_inst_o, mem_word(32'h100)); end
    endtask

    task automatic test_align();
        lat_lo = 1; lat_hi = 2;
        pc_load_i = 1; pc_load_addr_i = 32'h103;
        tick();
        pc_load_i = 0;
        #1;
        total++; if (imem_addr_o !== 32'h100) begin bad++; $display("FAIL align_addr got=%h want=00000100", imem_addr_o); end
        total++; if (imem_addr_o !== exp_fetch) begin bad++; $display("FAIL align_model got=%h want=%h", imem_addr_o, exp_fetch); end
    endtask

    task automatic test_wrap();
        int g0, k;
        lat_lo = 1; lat_hi = 1; gnt_pct = 100; incr_pc_i = 1;
        pc_load_i = 1; pc_load_addr_i = 32'hFFFF_FFFC;
        tick();
        pc_load_i = 0;
        g0 = grant_log.size();
        for (k = 0; k < 20 && grant_log.size() < g0 + 2; k++) tick();
        total++; if (grant_log.size() < g0 + 2) begin bad++; $display("FAIL wrap_grants got=%0d want=2", grant_log.size() - g0); end
        else begin
            total++; if (grant_log[g0] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%h want=fffffffc", grant_log[g0]); end
            total++; if (grant_log[g0 + 1] !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h want=00000000", grant_log[g0 + 1]); end
        end
    endtask

    task automatic test_random();
        gnt_pct = 70; lat_lo = 1; lat_hi = 3;
        for (int c = 0; c < 500; c++) begin
            incr_pc_i = $urandom_range(3, 0) != 0;
            pc_load_i = $urandom_range(15, 0) == 0;
            pc_load_addr_i = $urandom;
            #1;
            total++; if (d_valid_o !== (exp_q.size() > 0)) begin bad++; $display("FAIL rnd_dvalid c=%0d got=%b want=%b", c, d_valid_o, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                total++; if (d_pc_o !== exp_q[0].pc || d_inst_o !== exp_q[0].inst) begin bad++; $display("FAIL rnd_head c=%0d got=%h/%h want=%h/%h", c, d_pc_o, d_inst_o, exp_q[0].pc, exp_q[0].inst); end
            end else begin
                total++; if (d_inst_o !== NOP) begin bad++; $display("FAIL rnd_nop c=%0d got=%h want=%h", c, d_inst_o, NOP); end
            end
            total++; if (x_pc_o !== exp_x_pc) begin bad++; $display("FAIL rnd_xpc c=%0d got=%h want=%h", c, x_pc_o, exp_x_pc); end
            total++; if (imem_req_o !== (!pc_load_i && live_cnt() + exp_q.size() < DEPTH)) begin bad++; $display("FAIL rnd_req c=%0d got=%b live=%0d buf=%0d", c, imem_req_o, live_cnt(), exp_q.size()); end
            if (imem_req_o === 1'b1) begin
                total++; if (imem_addr_o !== exp_fetch) begin bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, imem_addr_o, exp_fetch); end
            end
            tick();
        end
        pc_load_i = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        gnt_pct = 100; lat_lo = 2; lat_hi = 2; incr_pc_i = 1;
        repeat (5) tick();
        rst_n_i = 0;
        imem_rvalid_i = 0;
        #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b want=0", imem_req_o); end
        total++; if (d_valid_o !== 1'b0 || d_inst_o !== NOP) begin bad++; $display("FAIL midrst_dinst got=%b/%h want=0/%h", d_valid_o, d_inst_o, NOP); end
        total++; if (d_pc_o !== 32'h0 || x_pc_o !== 32'h0) begin bad++; $display("FAIL midrst_pcs got=%h/%h want=0/0", d_pc_o, x_pc_o); end
        total++; if (imem_addr_o !== RESET_PC) begin bad++; $display("FAIL midrst_addr got=%h want=%h", imem_addr_o, RESET_PC); end
        model_reset();
        repeat (2) tick();
        rst_n_i = 1;
        imem_gnt_i = 1;
        #1;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin bad++; $display("FAIL midrst_restart got=%b/%h want=1/%h", imem_req_o, imem_addr_o, RESET_PC); end
        for (k = 0; k < 20 && d_valid_o !== 1'b1; k++) tick();
        total++; if (d_valid_o !== 1'b1 || d_pc_o !== RESET_PC) begin bad++; $display("FAIL midrst_first_pc got=%b/%h want=1/%h", d_valid_o, d_pc_o, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_align();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction presented when no valid instruction is available.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 incr_pc_i  in  1  decode consumes d_inst_o this cycle; low means stall.
REQ-006 pc_load_i  in  1  redirect: taken branch or jump.
REQ-007 pc_load_addr_i  in  32  redirect target.
REQ-008 imem_req_o  out  1  fetch request valid.
REQ-009 imem_addr_o  out  32  fetch address, word aligned.
REQ-010 imem_gnt_i  in  1  request accepted when imem_req_o and imem_gnt_i are both high.
REQ-011 imem_rvalid_i  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-012 imem_rdata_i  in  32  response instruction.
REQ-013 d_inst_o  out  32  instruction presented to decode.
REQ-014 d_valid_o  out  1  d_inst_o is a fetched instruction, not NOP_INST.
REQ-015 d_pc_o  out  32  PC of d_inst_o.
REQ-016 x_pc_o  out  32  PC of the instruction last consumed by decode.

Function
REQ-017 fetch_pc register: advances by 4 on each grant and is loaded with {pc_load_addr_i[31:2],2'b00} on pc_load_i.
REQ-018 imem_addr_o = fetch_pc; imem_req_o high when outstanding + buffered < DEPTH and pc_load_i is low.
REQ-019 Buffer: in-order FIFO of {inst, pc}; each accepted response writes the next entry, tagged with its request address.
REQ-020 d_inst_o/d_pc_o/d_valid_o show the FIFO head combinationally; when empty, d_inst_o = NOP_INST, d_valid_o = 0, d_pc_o = last head PC.
REQ-021 incr_pc_i high with a non-empty FIFO pops the head and loads x_pc_o with the head PC; with an empty FIFO nothing changes.
REQ-022 incr_pc_i low holds the head and x_pc_o unchanged.
REQ-023 Simultaneous pop and response on a full FIFO: both take effect and occupancy is unchanged.
REQ-024 pc_load_i (priority over all other events):
  - empties the FIFO and sets the discard count to the number of in-flight requests;
  - ignores incr_pc_i that cycle;
  - first request to the new address is issued the following cycle.
REQ-025 While discard count is non-zero, each imem_rvalid_i decrements it and the data is dropped.
REQ-026 A response arriving in the same cycle as pc_load_i is discarded.
REQ-027 fetch_pc wraps modulo 2^32.
REQ-028 Latency: grant at cycle n, rvalid at cycle n+k -> d_valid_o high in cycle n+k+1.

Reset
REQ-029 rst_n_i low clears the FIFO, the outstanding count and the discard count.
REQ-030 During reset: fetch_pc = RESET_PC, x_pc_o = 0, imem_req_o = 0, d_valid_o = 0, d_inst_o = NOP_INST, d_pc_o = 0.
REQ-031 First request is issued in the first clock after rst_n_i deasserts.
REQ-032 Responses to requests granted before reset are not expected.

Configuration
REQ-033 Macro FETCH_PREFETCH_EN defined: DEPTH = 2 (2-entry FIFO, up to 2 outstanding requests); absent: DEPTH = 1 (single entry, single outstanding request). All other behaviour is identical.

Verification
REQ-034 Reset release, gnt always 1, rvalid 1 cycle later, incr_pc_i = 1 -> addresses 0x0,0x4,0x8; d_pc_o follows in order; d_valid_o first high in cycle 3.
REQ-035 Stall: incr_pc_i = 0 for 5 cycles with PREFETCH -> at most 2 requests issued; d_inst_o held; x_pc_o unchanged.
REQ-036 pc_load_i with addr 0x100 while 2 requests are in flight -> both responses dropped; next request to 0x100; first valid d_pc_o = 0x100.
REQ-037 pc_load_addr_i = 0x103 -> imem_addr_o = 0x100.
REQ-038 fetch_pc = 0xFFFF_FFFC granted -> next request address 0x0000_0000.
REQ-039 rst_n_i asserted mid-fetch -> all outputs at reset values immediately; restart from RESET_PC.
